// File: rtl/uart_tx_sched.sv
// Shares the single UART write port between seed-pair, direction and keep-alive ping requesters.
// Frames 2-bit-opcode bytes: 00 dir, 01 seed x, 10 seed y, 11 ping; x and y are never split.
module uart_tx_sched #(
    parameter int unsigned PING_PERIOD = 1_000_000,
    parameter int unsigned CNT_W       = $clog2(PING_PERIOD + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_rdy,
    input  logic [5:0] seed_x_in,
    input  logic [5:0] seed_y_in,
    input  logic       send,
    input  logic [2:0] dir1,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       dropped
);

    localparam int unsigned CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] C_LAST = CW'((PING_PERIOD == 0) ? 0 : PING_PERIOD - 1);

    typedef enum logic {S_IDLE, S_SEED_Y} state_t;

    state_t        r_state, w_state_n;
    logic          r_send_prv;
    logic          r_seed_pend, r_dir_pend, r_ping_pend;
    logic [5:0]    r_seed_x, r_seed_y, r_y_cur;
    logic [2:0]    r_dir;
    logic [CW-1:0] r_cnt;
    logic          r_wr, r_busy, r_dropped;
    logic [7:0]    r_data;

    logic          w_send_rise, w_elig;
    logic          w_take_seed, w_take_dir, w_take_ping, w_ping_fire;
    logic          w_wr_n;
    logic [7:0]    w_data_n;
    logic [5:0]    w_y_cur_n;
    logic          w_seed_pend_n, w_dir_pend_n, w_ping_pend_n;
    logic [CW-1:0] w_cnt_n;
    logic          w_busy_n, w_dropped_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_wr_n      = 1'b0;
        w_data_n    = r_data;
        w_y_cur_n   = r_y_cur;
        w_take_seed = 1'b0;
        w_take_dir  = 1'b0;
        w_take_ping = 1'b0;
        w_send_rise = send & ~r_send_prv;
        w_elig      = ~tx_full & ~r_wr;

        case (r_state)
            S_IDLE: begin
                if (w_elig) begin
                    if (r_seed_pend) begin
                        w_take_seed = 1'b1;
                        w_wr_n      = 1'b1;
                        w_data_n    = {2'b01, r_seed_x};
                        w_y_cur_n   = r_seed_y;
                        w_state_n   = S_SEED_Y;
                    end else if (r_dir_pend) begin
                        w_take_dir = 1'b1;
                        w_wr_n     = 1'b1;
                        w_data_n   = {5'b00000, r_dir};
                    end else if (r_ping_pend) begin
                        w_take_ping = 1'b1;
                        w_wr_n      = 1'b1;
                        w_data_n    = 8'hC0;
                    end
                end
            end
            S_SEED_Y: begin
                if (w_elig) begin
                    w_wr_n    = 1'b1;
                    w_data_n  = {2'b10, r_y_cur};
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // A capture in the same cycle as the write re-arms the flag with the new value.
        w_seed_pend_n = seed_rdy    | (r_seed_pend & ~w_take_seed);
        w_dir_pend_n  = w_send_rise | (r_dir_pend  & ~w_take_dir);

        w_ping_fire   = (PING_PERIOD != 0) && !r_ping_pend && (r_cnt == C_LAST);
        w_ping_pend_n = w_ping_fire | (r_ping_pend & ~w_take_ping);

        if (PING_PERIOD == 0 || r_wr || w_ping_fire) begin
            w_cnt_n = '0;
        end else if (r_ping_pend) begin
            w_cnt_n = r_cnt;
        end else begin
            w_cnt_n = r_cnt + CW'(1);
        end

        w_dropped_n = (seed_rdy    & r_seed_pend & ~w_take_seed)
                    | (w_send_rise & r_dir_pend  & ~w_take_dir);
        w_busy_n    = w_seed_pend_n | w_dir_pend_n | w_ping_pend_n
                    | (w_state_n == S_SEED_Y) | w_wr_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_send_prv  <= 1'b1;
            r_seed_pend <= 1'b0;
            r_dir_pend  <= 1'b0;
            r_ping_pend <= 1'b0;
            r_seed_x    <= '0;
            r_seed_y    <= '0;
            r_y_cur     <= '0;
            r_dir       <= '0;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_send_prv  <= send;
            r_seed_pend <= w_seed_pend_n;
            r_dir_pend  <= w_dir_pend_n;
            r_ping_pend <= w_ping_pend_n;
            if (seed_rdy) begin
                r_seed_x <= seed_x_in;
                r_seed_y <= seed_y_in;
            end
            if (w_send_rise) begin
                r_dir <= dir1;
            end
            r_y_cur     <= w_y_cur_n;
            r_cnt       <= w_cnt_n;
            r_wr        <= w_wr_n;
            r_data      <= w_data_n;
            r_busy      <= w_busy_n;
            r_dropped   <= w_dropped_n;
        end
    end

    assign wr_uart = r_wr;
    assign w_data  = r_data;
    assign busy    = r_busy;
    assign dropped = r_dropped;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed protocol scenarios plus randomized traffic,
// all cycles compared against a request-level reference model.
module tb_uart_tx_sched;

    localparam int unsigned P = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seed_rdy = 1'b0;
    logic [5:0] seed_x_in = '0;
    logic [5:0] seed_y_in = '0;
    logic       send = 1'b0;
    logic [2:0] dir1 = '0;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       busy;
    logic       dropped;

    always #5 clk = ~clk;

    uart_tx_sched #(.PING_PERIOD(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .seed_rdy (seed_rdy),
        .seed_x_in(seed_x_in),
        .seed_y_in(seed_y_in),
        .send     (send),
        .dir1     (dir1),
        .tx_full  (tx_full),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .busy     (busy),
        .dropped  (dropped)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nwr    = 0;
    int ndrop  = 0;

    // Reference model: outstanding requests, an owed y byte, idle-cycle count.
    bit         mw, mb, md;
    logic [7:0] mdata;
    bit         s_v, d_v, p_v, y_v, sprev;
    logic [5:0] s_x, s_y, y_y;
    logic [2:0] d_d;
    int         idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mw = 0; mb = 0; md = 0; mdata = '0;
        s_v = 0; d_v = 0; p_v = 0; y_v = 0; sprev = 1; idle = 0;
    endtask

    task automatic model_step();
        bit         free, nw, p_old, fire, rise;
        logic [7:0] nd;
        free  = !tx_full && !mw;
        nw    = 0;
        nd    = mdata;
        p_old = p_v;
        if (free) begin
            if (y_v) begin
                nw = 1; nd = {2'b10, y_y}; y_v = 0;
            end else if (s_v) begin
                nw = 1; nd = {2'b01, s_x}; y_v = 1; y_y = s_y; s_v = 0;
            end else if (d_v) begin
                nw = 1; nd = {5'b0, d_d}; d_v = 0;
            end else if (p_v) begin
                nw = 1; nd = 8'hC0; p_v = 0;
            end
        end
        fire = !p_old && (idle == int'(P) - 1);
        if (mw || fire) idle = 0;
        else if (!p_old) idle = idle + 1;
        if (fire) p_v = 1;
        rise  = send && !sprev;
        sprev = send;
        md = (seed_rdy && s_v) || (rise && d_v);
        if (seed_rdy) begin s_v = 1; s_x = seed_x_in; s_y = seed_y_in; end
        if (rise) begin d_v = 1; d_d = dir1; end
        mb    = s_v || d_v || p_v || y_v || nw;
        mw    = nw;
        mdata = nd;
    endtask

    task automatic tick();
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (wr_uart === 1'b1) nwr++;
        if (dropped === 1'b1) ndrop++;
        chk("wr_uart", 32'(wr_uart), 32'(mw));
        chk("w_data",  32'(w_data),  32'(mdata));
        chk("busy",    32'(busy),    32'(mb));
        chk("dropped", 32'(dropped), 32'(md));
    endtask

    task automatic run_until_write(input int limit, output int c, output logic [7:0] b);
        c = -1;
        b = 'x;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (wr_uart === 1'b1) begin
                c = cyc;
                b = w_data;
                return;
            end
        end
    endtask

    task automatic do_reset();
        seed_rdy = 0; send = 0; tx_full = 0; rst = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    initial begin
        int         t0, c, n0;
        logic [7:0] b;
        logic [5:0] rx, ry;
        logic [2:0] rd;

        // Reset state, then ping cadence on an idle link
        tick();
        tick();
        chk("rst_wr",   32'(wr_uart), 32'd0);
        chk("rst_data", 32'(w_data),  32'd0);
        chk("rst_busy", 32'(busy),    32'd0);
        chk("rst_drop", 32'(dropped), 32'd0);
        rst = 0;
        t0 = cyc;
        run_until_write(40, c, b);
        chk("ping1_cyc", 32'(c - t0), 32'(P + 1));
        chk("ping1_byte", 32'(b), 32'hC0);
        run_until_write(40, c, b);
        chk("ping2_cyc", 32'(c - t0), 32'(2 * P + 3));
        chk("ping2_byte", 32'(b), 32'hC0);
        for (int i = 0; i < 4; i++) tick();
        send = 1; dir1 = 3'd5; t0 = cyc;
        run_until_write(10, c, b);
        chk("dirw_cyc", 32'(c - t0), 32'd2);
        chk("dirw_byte", 32'(b), 32'h05);
        run_until_write(40, c, b);
        chk("ping3_after_dir", 32'(c - t0), 32'(2 + P + 2));
        chk("ping3_byte", 32'(b), 32'hC0);

        // Single seed pair
        do_reset();
        seed_rdy = 1; seed_x_in = 6'h15; seed_y_in = 6'h2A; t0 = cyc;
        tick();
        seed_rdy = 0;
        run_until_write(10, c, b);
        chk("seedx_cyc", 32'(c - t0), 32'd2);
        chk("seedx_byte", 32'(b), 32'h55);
        run_until_write(10, c, b);
        chk("seedy_cyc", 32'(c - t0), 32'd4);
        chk("seedy_byte", 32'(b), 32'hAA);
        chk("busy_c4", 32'(busy), 32'd1);
        tick();
        chk("busy_c5", 32'(busy), 32'd0);

        // Seed and direction in the same cycle
        do_reset();
        seed_rdy = 1; seed_x_in = 6'd1; seed_y_in = 6'd2; send = 1; dir1 = 3'd3; t0 = cyc;
        tick();
        seed_rdy = 0;
        run_until_write(10, c, b);
        chk("cont1", 32'({c - t0, 24'(b)}), 32'({8'd2, 24'h41}));
        run_until_write(10, c, b);
        chk("cont2", 32'({c - t0, 24'(b)}), 32'({8'd4, 24'h82}));
        run_until_write(10, c, b);
        chk("cont3", 32'({c - t0, 24'(b)}), 32'({8'd6, 24'h03}));

        // Backpressure between x and y with a direction request in the window
        do_reset();
        rx = 6'($urandom); ry = 6'($urandom); rd = 3'($urandom);
        seed_rdy = 1; seed_x_in = rx; seed_y_in = ry; t0 = cyc;
        tick();
        seed_rdy = 0;
        run_until_write(10, c, b);
        chk("bp_x", 32'({c - t0, 24'(b)}), 32'({8'd2, 16'h0, 2'b01, rx}));
        tx_full = 1;
        n0 = nwr;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin send = 1; dir1 = rd; end
            tick();
        end
        chk("bp_stalled", 32'(nwr - n0), 32'd0);
        tx_full = 0;
        run_until_write(10, c, b);
        chk("bp_y", 32'({c - t0, 24'(b)}), 32'({8'd13, 16'h0, 2'b10, ry}));
        run_until_write(10, c, b);
        chk("bp_dir", 32'({c - t0, 24'(b)}), 32'({8'd15, 21'h0, rd}));

        // Direction overwrite while stalled
        do_reset();
        tx_full = 1; n0 = ndrop;
        send = 1; dir1 = 3'd1;
        tick();
        send = 0;
        tick();
        send = 1; dir1 = 3'd2;
        for (int i = 0; i < 4; i++) tick();
        chk("ovr_drops", 32'(ndrop - n0), 32'd1);
        tx_full = 0;
        run_until_write(10, c, b);
        chk("ovr_byte", 32'(b), 32'h02);
        n0 = nwr;
        for (int i = 0; i < 10; i++) tick();
        chk("ovr_only_one", 32'(nwr - n0), 32'd0);

        // Reset right after the x byte, with send held high across release
        do_reset();
        seed_rdy = 1; seed_x_in = 6'h0F; seed_y_in = 6'h30;
        tick();
        seed_rdy = 0;
        run_until_write(10, c, b);
        rst = 1; send = 1;
        tick();
        chk("mid_rst_wr",   32'(wr_uart), 32'd0);
        chk("mid_rst_data", 32'(w_data),  32'd0);
        chk("mid_rst_busy", 32'(busy),    32'd0);
        chk("mid_rst_drop", 32'(dropped), 32'd0);
        rst = 0;
        n0 = nwr;
        for (int i = 0; i < 12; i++) tick();
        chk("no_y_after_rst", 32'(nwr - n0), 32'd0);
        send = 0;

        // Randomized traffic: dense, then sparse enough for pings
        for (int i = 0; i < 900; i++) begin
            seed_rdy  = ($urandom_range(0, 7) == 0);
            seed_x_in = 6'($urandom);
            seed_y_in = 6'($urandom);
            if ($urandom_range(0, 3) == 0) send = ~send;
            dir1      = 3'($urandom);
            tx_full   = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        for (int i = 0; i < 900; i++) begin
            seed_rdy  = ($urandom_range(0, 63) == 0);
            seed_x_in = 6'($urandom);
            seed_y_in = 6'($urandom);
            if ($urandom_range(0, 31) == 0) send = ~send;
            dir1      = 3'($urandom);
            tx_full   = ($urandom_range(0, 5) == 0);
            rst       = 1'b0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
